mux_arbiter: RTL and testbench

MUX_ARBITER -- requirements
Module: mux_arbiter

---
 rtl/mux_arbiter_pkg.sv | 20 ++
 rtl/mux_arbiter_rr_picker.sv | 27 ++
 rtl/mux_arbiter.sv | 118 +++++++++++
 tb/tb_mux_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mux_arbiter_pkg.sv
// Shared sizes, FSM state encoding and helpers for the round-robin 4:1 mux arbiter.
package mux_arbiter_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned SEL_W   = 2;
    localparam int unsigned CNT_W   = 8;

    typedef enum logic {
        StIdle  = 1'b0,
        StOwned = 1'b1
    } state_e;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux_arbiter_rr_picker.sv
// Combinational round-robin picker: first asserted request scanning last+1 .. last+4 (mod 4).
module rr_picker
    import mux_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [SEL_W-1:0]   last_i,
    output logic [SEL_W-1:0]   winner_o,
    output logic               valid_o
);

    logic [SEL_W-1:0] idx;

    // Scan farthest-first so the nearest asserted requester overwrites earlier hits.
    always_comb begin
        winner_o = last_i;
        valid_o  = 1'b0;
        idx      = last_i;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = last_i + SEL_W'(k);
            if (req_i[idx]) begin
                winner_o = idx;
                valid_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_arbiter.sv
// Two-state round-robin arbiter for a shared 4:1 mux; all outputs registered.
// Optional hold-time limit enabled by defining MUX_ARBITER_TIMEOUT_EN.
module mux_arbiter
    import mux_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [SEL_W-1:0]   sel_o,
    output logic               busy_o,
    output logic               timeout_o
);

    state_e             state_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic [SEL_W-1:0]   sel_q;
    logic [SEL_W-1:0]   last_q;
    logic               busy_q;

    logic [SEL_W-1:0]   winner;
    logic               winner_vld;

    rr_picker u_rr_picker (
        .req_i    (req_i),
        .last_i   (last_q),
        .winner_o (winner),
        .valid_o  (winner_vld)
    );

`ifdef MUX_ARBITER_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q;
    logic             timeout_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            gnt_q     <= '0;
            sel_q     <= '0;
            last_q    <= SEL_W'(NUM_REQ - 1);
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (winner_vld) begin
                        state_q <= StOwned;
                        gnt_q   <= onehot(winner);
                        sel_q   <= winner;
                        last_q  <= winner;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                StOwned: begin
                    if (!req_i[sel_q]) begin
                        state_q <= StIdle;
                        gnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        // Forced release; last_q already holds the owner for fair rescan.
                        state_q   <= StIdle;
                        gnt_q     <= '0;
                        busy_q    <= 1'b0;
                        timeout_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign timeout_o = timeout_q;
`else
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            sel_q   <= '0;
            last_q  <= SEL_W'(NUM_REQ - 1);
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (winner_vld) begin
                        state_q <= StOwned;
                        gnt_q   <= onehot(winner);
                        sel_q   <= winner;
                        last_q  <= winner;
                        busy_q  <= 1'b1;
                    end
                end
                StOwned: begin
                    if (!req_i[sel_q]) begin
                        state_q <= StIdle;
                        gnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign timeout_o = 1'b0;
`endif

    assign gnt_o  = gnt_q;
    assign sel_o  = sel_q;
    assign busy_o = busy_q;

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed and random checks for mux_arbiter; timeout steps follow MUX_ARBITER_TIMEOUT_EN.
module tb_mux_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       to;

    int errors = 0;
    int checks = 0;

    // Reference model state for the random phase
    logic       m_state;
    logic [3:0] m_gnt;
    logic [1:0] m_sel;
    logic [1:0] m_last;
    logic       m_busy;
    logic       m_to;
    int         m_cnt;

    always #5 clk = ~clk;

    mux_arbiter #(.TIMEOUT(4)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .req_i     (req),
        .gnt_o     (gnt),
        .sel_o     (sel),
        .busy_o    (busy),
        .timeout_o (to)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [3:0] g, input logic [1:0] s,
                              input logic b, input logic t);
        chk({tag, ".gnt"}, 32'(gnt), 32'(g));
        chk({tag, ".sel"}, 32'(sel), 32'(s));
        chk({tag, ".busy"}, 32'(busy), 32'(b));
        chk({tag, ".timeout"}, 32'(to), 32'(t));
    endtask

    task automatic model_reset();
        m_state = 1'b0;
        m_gnt   = 4'b0;
        m_sel   = 2'd0;
        m_last  = 2'd3;
        m_busy  = 1'b0;
        m_to    = 1'b0;
        m_cnt   = 0;
    endtask

    task automatic model_step(input logic [3:0] r);
        logic       found;
        logic [1:0] idx;
        m_to  = 1'b0;
        found = 1'b0;
        if (!m_state) begin
            for (int k = 1; k <= 4; k++) begin
                idx = 2'((int'(m_last) + k) % 4);
                if (!found && r[idx]) begin
                    found   = 1'b1;
                    m_state = 1'b1;
                    m_gnt   = 4'b1 << idx;
                    m_sel   = idx;
                    m_last  = idx;
                    m_busy  = 1'b1;
                    m_cnt   = 0;
                end
            end
        end else if (!r[m_sel]) begin
            m_state = 1'b0;
            m_gnt   = 4'b0;
            m_busy  = 1'b0;
        end else begin
`ifdef MUX_ARBITER_TIMEOUT_EN
            if (m_cnt == 3) begin
                m_state = 1'b0;
                m_gnt   = 4'b0;
                m_busy  = 1'b0;
                m_to    = 1'b1;
            end else begin
                m_cnt++;
            end
`endif
        end
    endtask

    initial begin
        logic [3:0] r;
        logic [3:0] prev_gnt;
        int         wait_cnt[4];

        rst = 1'b1;
        req = 4'b0000;
        #12;
        expect_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst = 1'b0;

        // All request: requester 0 wins first
        req = 4'b1111;
        step();
        expect_out("first_grant", 4'b0001, 2'd0, 1'b1, 1'b0);
        step();
        expect_out("hold0", 4'b0001, 2'd0, 1'b1, 1'b0);

        // Rotation with one-cycle turnaround
        req = 4'b1110;
        step();
        expect_out("rel0", 4'b0000, 2'd0, 1'b0, 1'b0);
        step();
        expect_out("grant1", 4'b0010, 2'd1, 1'b1, 1'b0);
        req = 4'b1101;
        step();
        expect_out("rel1", 4'b0000, 2'd1, 1'b0, 1'b0);
        step();
        expect_out("grant2", 4'b0100, 2'd2, 1'b1, 1'b0);
        req = 4'b1011;
        step();
        expect_out("rel2", 4'b0000, 2'd2, 1'b0, 1'b0);
        step();
        expect_out("grant3", 4'b1000, 2'd3, 1'b1, 1'b0);
        req = 4'b0111;
        step();
        expect_out("rel3", 4'b0000, 2'd3, 1'b0, 1'b0);
        step();
        expect_out("wrap0", 4'b0001, 2'd0, 1'b1, 1'b0);
        req = 4'b0000;
        step();
        expect_out("idle_a", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Lone requester 2 for three cycles
        req = 4'b0100;
        step();
        expect_out("solo2_c1", 4'b0100, 2'd2, 1'b1, 1'b0);
        step();
        expect_out("solo2_c2", 4'b0100, 2'd2, 1'b1, 1'b0);
        step();
        expect_out("solo2_c3", 4'b0100, 2'd2, 1'b1, 1'b0);
        req = 4'b0000;
        step();
        expect_out("solo2_rel", 4'b0000, 2'd2, 1'b0, 1'b0);
        step();
        expect_out("solo2_idle", 4'b0000, 2'd2, 1'b0, 1'b0);

        // Requester 1 held continuously
        req = 4'b0010;
`ifdef MUX_ARBITER_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            step();
            expect_out("to_hold", 4'b0010, 2'd1, 1'b1, 1'b0);
        end
        step();
        expect_out("to_pulse", 4'b0000, 2'd1, 1'b0, 1'b1);
        step();
        expect_out("to_regrant", 4'b0010, 2'd1, 1'b1, 1'b0);
`else
        for (int i = 0; i < 12; i++) begin
            step();
            expect_out("unbounded", 4'b0010, 2'd1, 1'b1, 1'b0);
        end
`endif
        req = 4'b0000;
        step();
        expect_out("idle_b", 4'b0000, 2'd1, 1'b0, 1'b0);

        // Asynchronous reset mid-ownership
        req = 4'b0100;
        step();
        expect_out("pre_rst", 4'b0100, 2'd2, 1'b1, 1'b0);
        #3 rst = 1'b1;
        #1;
        expect_out("async_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
        #2 rst = 1'b0;
        req = 4'b1111;
        step();
        expect_out("post_rst", 4'b0001, 2'd0, 1'b1, 1'b0);

        // Random phase against the reference model
        req = 4'b0000;
        #2 rst = 1'b1;
        #1 rst = 1'b0;
        model_reset();
        prev_gnt = 4'b0000;
        for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
        for (int c = 0; c < 10000; c++) begin
            r   = 4'($urandom_range(0, 15));
            req = r;
            step();
            model_step(r);
            chk("rnd.gnt", 32'(gnt), 32'(m_gnt));
            chk("rnd.sel", 32'(sel), 32'(m_sel));
            chk("rnd.busy", 32'(busy), 32'(m_busy));
            chk("rnd.timeout", 32'(to), 32'(m_to));
            chk("rnd.onehot0", 32'($onehot0(gnt)), 32'd1);
            chk("rnd.busy_iff_gnt", 32'(busy), 32'(gnt != 4'b0000));
            for (int i = 0; i < 4; i++) begin
                if (!r[i]) wait_cnt[i] = 0;
                else if (gnt != 4'b0000 && prev_gnt == 4'b0000) begin
                    if (gnt[i]) wait_cnt[i] = 0;
                    else wait_cnt[i]++;
                end
            end
            chk("rnd.starve", 32'(wait_cnt[0] <= 3 && wait_cnt[1] <= 3 &&
                                  wait_cnt[2] <= 3 && wait_cnt[3] <= 3), 32'd1);
            prev_gnt = gnt;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
